// File: rtl/sdram_arbiter.sv
// Two-port (CPU 32-bit, DMA 16-bit) time-slot arbiter in front of a 16-bit SDRAM controller.
// Define SDRAM_ARB_DMA_EN to enable the DMA port; otherwise every non-refresh slot belongs to the CPU.
module sdram_arbiter #(
    parameter int REFRESH_SLOTS = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [24:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    input  logic        dma_valid,
    input  logic [24:0] dma_addr,
    output logic        dma_ready,
    output logic [15:0] dma_rdata,
    output logic        sd_clkref,
    output logic        sd_we,
    output logic        sd_oe,
    output logic [24:0] sd_addr,
    output logic [15:0] sd_din,
    output logic [1:0]  sd_dqm,
    input  logic [15:0] sd_dout
);
`ifdef SDRAM_ARB_DMA_EN
    localparam bit DMA_EN = 1'b1;
`else
    localparam bit DMA_EN = 1'b0;
`endif
    localparam int CNT_W = $clog2(REFRESH_SLOTS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_SLOTS - 1);

    typedef enum logic [1:0] {GNT_IDLE, GNT_CPU_LO, GNT_CPU_HI, GNT_DMA} gnt_t;

    gnt_t             gnt;
    logic [3:0]       phase;
    logic [CNT_W-1:0] slot_cnt;
    logic             cpu_pend;
    logic             rr_dma;
    logic             gnt_last;
    logic             dma_req;
    logic             cpu_rd;
    logic             lo_need;
    logic             hi_need;
    logic             unused_bits;

    assign dma_req     = DMA_EN && dma_valid;
    assign cpu_rd      = (mem_wstrb == 4'b0000);
    assign lo_need     = cpu_rd || (mem_wstrb[1:0] != 2'b00);
    assign hi_need     = cpu_rd || (mem_wstrb[3:2] != 2'b00);
    assign sd_clkref   = phase[3];
    assign unused_bits = ^{mem_addr[1:0], dma_addr[0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase     <= 4'd0;
            slot_cnt  <= '0;
            cpu_pend  <= 1'b0;
            rr_dma    <= 1'b0;
            gnt       <= GNT_IDLE;
            gnt_last  <= 1'b0;
            sd_we     <= 1'b0;
            sd_oe     <= 1'b0;
            sd_addr   <= '0;
            sd_din    <= '0;
            sd_dqm    <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            dma_ready <= 1'b0;
            dma_rdata <= '0;
        end else begin
            phase     <= phase + 4'd1;
            mem_ready <= 1'b0;
            dma_ready <= 1'b0;

            // Data capture at phase 12 so the ready pulse and data appear together at phase 13.
            if (phase == 4'd12) begin
                case (gnt)
                    GNT_CPU_LO: begin
                        if (sd_oe) mem_rdata[15:0] <= sd_dout;
                        mem_ready <= gnt_last;
                    end
                    GNT_CPU_HI: begin
                        if (sd_oe) mem_rdata[31:16] <= sd_dout;
                        mem_ready <= gnt_last;
                    end
                    GNT_DMA: begin
                        dma_rdata <= sd_dout;
                        dma_ready <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (phase == 4'd15) begin
                gnt      <= GNT_IDLE;
                gnt_last <= 1'b0;
                sd_we    <= 1'b0;
                sd_oe    <= 1'b0;
                sd_addr  <= '0;
                sd_din   <= '0;
                sd_dqm   <= '0;
                if (slot_cnt == CNT_MAX) begin
                    // Forced refresh slot; a pending CPU high half survives it.
                    slot_cnt <= '0;
                end else if (cpu_pend) begin
                    slot_cnt <= slot_cnt + CNT_W'(1);
                    cpu_pend <= 1'b0;
                    gnt      <= GNT_CPU_HI;
                    gnt_last <= 1'b1;
                    sd_we    <= !cpu_rd;
                    sd_oe    <= cpu_rd;
                    sd_addr  <= {mem_addr[24:2], 2'b10};
                    sd_din   <= mem_wdata[31:16];
                    sd_dqm   <= mem_wstrb[3:2];
                end else if (mem_valid && !(dma_req && rr_dma)) begin
                    slot_cnt <= slot_cnt + CNT_W'(1);
                    if (dma_req) rr_dma <= 1'b1;
                    sd_we <= !cpu_rd;
                    sd_oe <= cpu_rd;
                    if (lo_need) begin
                        cpu_pend <= hi_need;
                        gnt      <= GNT_CPU_LO;
                        gnt_last <= !hi_need;
                        sd_addr  <= {mem_addr[24:2], 2'b00};
                        sd_din   <= mem_wdata[15:0];
                        sd_dqm   <= mem_wstrb[1:0];
                    end else begin
                        gnt      <= GNT_CPU_HI;
                        gnt_last <= 1'b1;
                        sd_addr  <= {mem_addr[24:2], 2'b10};
                        sd_din   <= mem_wdata[31:16];
                        sd_dqm   <= mem_wstrb[3:2];
                    end
                end else if (dma_req) begin
                    slot_cnt <= slot_cnt + CNT_W'(1);
                    if (mem_valid) rr_dma <= 1'b0;
                    gnt      <= GNT_DMA;
                    gnt_last <= 1'b1;
                    sd_oe    <= 1'b1;
                    sd_addr  <= {dma_addr[24:1], 1'b0};
                end else begin
                    slot_cnt <= '0;
                end
            end
        end
    end
endmodule
